// File: rtl/parity_pkg.sv
// Shared types and helpers for the streaming two-dimensional parity checker.
package parity_pkg;

    // Frame sequencing: data words, then the column check word, then a one-cycle report.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        REPORT  = 2'd2
    } state_t;

    // Widest data word the row-parity helper accepts; narrower words are zero-padded,
    // which leaves their XOR reduction unchanged.
    localparam int MAX_DATA_W = 64;

    // Index width able to address words 0..frame_len (the check word sits at frame_len).
    function automatic int idx_width(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

    // Row error: the word plus its parity bit does not reduce to the selected parity.
    function automatic logic row_parity_err(input logic [MAX_DATA_W-1:0] data,
                                            input logic                  par,
                                            input logic                  odd);
        return (^{data, par}) != odd;
    endfunction

endpackage

// File: rtl/parity_row_check.sv
// Combinational row-parity check of a single word against the active parity mode.
module parity_row_check
    import parity_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] data,
    input  logic              par,
    input  logic              odd,
    output logic              err
);

    logic [MAX_DATA_W-1:0] data_ext;

    // Zero-extend the word and apply the shared row-parity rule.
    always_comb begin
        data_ext               = '0;
        data_ext[DATA_W-1:0]   = data;
        err                    = row_parity_err(data_ext, par, odd);
    end

endmodule

// File: rtl/parity_frame_checker.sv
// Streaming 2D parity checker: per-word row parity, column parity via a check word,
// a one-cycle frame report, a saturating errored-frame counter and a sticky error flag.
// Handshake: a word transfers on a rising edge where in_valid && in_ready; in_ready is
// a pure decode of the FSM state and never depends on in_valid.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 odd_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_par,
    input  logic                 clr_stat,
    output logic                 out_valid,
    output logic [FRAME_LEN:0]   out_row_err,
    output logic [DATA_W-1:0]    out_col_err,
    output logic                 out_frame_err,
    output logic [CNT_W-1:0]     err_count,
    output logic                 sticky_err
);

    localparam int                IDX_W    = idx_width(FRAME_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]  CHK_IDX  = IDX_W'(FRAME_LEN);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                odd_q, odd_d;
    logic [DATA_W-1:0]   col_acc_q, col_acc_d;
    logic [FRAME_LEN:0]  row_acc_q, row_acc_d;
    logic                out_valid_q, out_valid_d;
    logic [FRAME_LEN:0]  out_row_err_q, out_row_err_d;
    logic [DATA_W-1:0]   out_col_err_q, out_col_err_d;
    logic                out_frame_err_q, out_frame_err_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic                sticky_q, sticky_d;

    logic                xfer;
    logic                first_word;
    logic                odd_eff;
    logic                row_err_w;
    logic [FRAME_LEN:0]  frame_row;
    logic [DATA_W-1:0]   frame_col;
    logic                frame_err;
    logic                stat_update;

    assign in_ready   = (state_q != REPORT);
    assign xfer       = in_valid && in_ready;
    assign first_word = (state_q == COLLECT) && (idx_q == '0);
    // The first word of a frame checks against the live mode, which is latched with it.
    assign odd_eff    = first_word ? odd_mode : odd_q;

    parity_row_check #(
        .DATA_W (DATA_W)
    ) u_row_check (
        .data (in_data),
        .par  (in_par),
        .odd  (odd_eff),
        .err  (row_err_w)
    );

    // Next-state logic for sequencing, accumulation, report and statistics.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        odd_d           = odd_q;
        col_acc_d       = col_acc_q;
        row_acc_d       = row_acc_q;
        out_valid_d     = 1'b0;
        out_row_err_d   = out_row_err_q;
        out_col_err_d   = out_col_err_q;
        out_frame_err_d = out_frame_err_q;
        err_count_d     = err_count_q;
        sticky_d        = sticky_q;

        frame_row            = row_acc_q;
        frame_row[FRAME_LEN] = row_err_w;
        frame_col            = col_acc_q ^ in_data ^ {DATA_W{odd_q}};
        frame_err            = (|frame_row) || (|frame_col);
        stat_update          = (state_q == CHECK) && xfer && frame_err;

        case (state_q)
            COLLECT: begin
                if (xfer) begin
                    if (first_word) begin
                        odd_d        = odd_mode;
                        col_acc_d    = in_data;
                        row_acc_d    = '0;
                        row_acc_d[0] = row_err_w;
                    end else begin
                        col_acc_d        = col_acc_q ^ in_data;
                        row_acc_d[idx_q] = row_err_w;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = CHECK;
                        idx_d   = CHK_IDX;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    state_d         = REPORT;
                    idx_d           = '0;
                    row_acc_d       = '0;
                    col_acc_d       = '0;
                    out_valid_d     = 1'b1;
                    out_row_err_d   = frame_row;
                    out_col_err_d   = frame_col;
                    out_frame_err_d = frame_err;
                end
            end
            REPORT: begin
                state_d = COLLECT;
                idx_d   = '0;
            end
            default: begin
                state_d = COLLECT;
                idx_d   = '0;
            end
        endcase

        // A clear coinciding with an errored report counts that frame after the clear.
        if (clr_stat) begin
            err_count_d = stat_update ? CNT_W'(1) : '0;
            sticky_d    = stat_update;
        end else if (stat_update) begin
            if (err_count_q != {CNT_W{1'b1}}) begin
                err_count_d = err_count_q + 1'b1;
            end
            sticky_d = 1'b1;
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= COLLECT;
            idx_q           <= '0;
            odd_q           <= 1'b0;
            col_acc_q       <= '0;
            row_acc_q       <= '0;
            out_valid_q     <= 1'b0;
            out_row_err_q   <= '0;
            out_col_err_q   <= '0;
            out_frame_err_q <= 1'b0;
            err_count_q     <= '0;
            sticky_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            odd_q           <= odd_d;
            col_acc_q       <= col_acc_d;
            row_acc_q       <= row_acc_d;
            out_valid_q     <= out_valid_d;
            out_row_err_q   <= out_row_err_d;
            out_col_err_q   <= out_col_err_d;
            out_frame_err_q <= out_frame_err_d;
            err_count_q     <= err_count_d;
            sticky_q        <= sticky_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_row_err   = out_row_err_q;
    assign out_col_err   = out_col_err_q;
    assign out_frame_err = out_frame_err_q;
    assign err_count     = err_count_q;
    assign sticky_err    = sticky_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker (DATA_W=4, FRAME_LEN=4, CNT_W=2): directed scenarios
// followed by randomized frames checked against a frame-level 2D parity model.
module tb_parity_frame_checker;

    localparam int DATA_W    = 4;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 odd_mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_data;
    logic                 in_par;
    logic                 clr_stat;
    logic                 out_valid;
    logic [FRAME_LEN:0]   out_row_err;
    logic [DATA_W-1:0]    out_col_err;
    logic                 out_frame_err;
    logic [CNT_W-1:0]     err_count;
    logic                 sticky_err;

    int n_checks = 0;
    int n_err    = 0;
    int rep_cnt  = 0;

    // Frame under test: words 0..FRAME_LEN-1 are data, index FRAME_LEN is the check word.
    logic [DATA_W-1:0] fr_d [FRAME_LEN+1];
    logic              fr_p [FRAME_LEN+1];

    // Statistics model.
    int   m_count  = 0;
    logic m_sticky = 1'b0;

    parity_frame_checker #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .odd_mode      (odd_mode),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_par        (in_par),
        .clr_stat      (clr_stat),
        .out_valid     (out_valid),
        .out_row_err   (out_row_err),
        .out_col_err   (out_col_err),
        .out_frame_err (out_frame_err),
        .err_count     (err_count),
        .sticky_err    (sticky_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_valid === 1'b1) rep_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word at a negedge and return at the negedge after it transfers.
    task automatic send_word(input logic [DATA_W-1:0] d, input logic p);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_par   = p;
        chk("ready_before_word", in_ready, 1'b1);
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("ready_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 15);
        in_par   = 1'($urandom_range(0, 1));
    endtask

    // Drive fr_d/fr_p as one frame, then check the report against the parity model.
    task automatic run_frame(input logic odd, input logic clr, input int max_gap,
                             input logic flip_odd);
        logic [FRAME_LEN:0]  e_row;
        logic [DATA_W-1:0]   e_col;
        logic                e_fe;
        int                  ones;
        int                  rep_before;
        rep_before = rep_cnt;
        odd_mode   = odd;
        for (int i = 0; i <= FRAME_LEN; i++) begin
            if (i == FRAME_LEN) clr_stat = clr;
            send_word(fr_d[i], fr_p[i]);
            clr_stat = 1'b0;
            if (i == 0 && flip_odd) odd_mode = ~odd;
            if (i < FRAME_LEN) begin
                int gap = $urandom_range(0, max_gap);
                for (int g = 0; g < gap; g++) begin
                    chk("ready_in_gap", in_ready, 1'b1);
                    @(negedge clk);
                end
            end
        end
        // Model: row i errs if its bits plus parity disagree with the mode;
        // column c errs if the count of ones down that column disagrees with the mode.
        for (int i = 0; i <= FRAME_LEN; i++)
            e_row[i] = ((($countones(fr_d[i]) + int'(fr_p[i])) % 2) != int'(odd));
        for (int c = 0; c < DATA_W; c++) begin
            ones = 0;
            for (int i = 0; i <= FRAME_LEN; i++) ones += int'(fr_d[i][c]);
            e_col[c] = ((ones % 2) != int'(odd));
        end
        e_fe = (e_row != '0) || (e_col != '0);
        if (clr) begin
            m_count  = e_fe ? 1 : 0;
            m_sticky = e_fe;
        end else if (e_fe) begin
            m_count  = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
            m_sticky = 1'b1;
        end
        chk("rep_valid",   out_valid, 1'b1);
        chk("rep_ready",   in_ready, 1'b0);
        chk("rep_row",     out_row_err, e_row);
        chk("rep_col",     out_col_err, e_col);
        chk("rep_fe",      out_frame_err, e_fe);
        chk("rep_count",   err_count, m_count);
        chk("rep_sticky",  sticky_err, m_sticky);
        @(negedge clk);
        chk("post_valid",  out_valid, 1'b0);
        chk("post_ready",  in_ready, 1'b1);
        chk("post_row",    out_row_err, e_row);
        chk("post_col",    out_col_err, e_col);
        chk("one_report",  rep_cnt - rep_before, 1);
    endtask

    task automatic load_frame(input logic [4:0] d0, input logic [4:0] d1, input logic [4:0] d2,
                              input logic [4:0] d3, input logic [4:0] d4);
        // Each argument is {par, data}.
        fr_d[0] = d0[3:0]; fr_p[0] = d0[4];
        fr_d[1] = d1[3:0]; fr_p[1] = d1[4];
        fr_d[2] = d2[3:0]; fr_p[2] = d2[4];
        fr_d[3] = d3[3:0]; fr_p[3] = d3[4];
        fr_d[4] = d4[3:0]; fr_p[4] = d4[4];
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst      = 1'b1;
        odd_mode = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_par   = 1'b0;
        clr_stat = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid",  out_valid, 1'b0);
        chk("rst_count",  err_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("init_ready",  in_ready, 1'b1);
        chk("init_row",    out_row_err, 0);
        chk("init_col",    out_col_err, 0);
        chk("init_fe",     out_frame_err, 1'b0);
        chk("init_sticky", sticky_err, 1'b0);

        // Even frame, clean.
        load_frame({1'b1,4'h1}, {1'b0,4'h3}, {1'b1,4'h7}, {1'b0,4'hF}, {1'b0,4'hA});
        run_frame(1'b0, 1'b0, 0, 1'b0);
        chk("clean_row",   out_row_err, 5'b00000);
        chk("clean_count", err_count, 0);

        // Single-bit error in word 2.
        load_frame({1'b1,4'h1}, {1'b0,4'h3}, {1'b1,4'h6}, {1'b0,4'hF}, {1'b0,4'hA});
        run_frame(1'b0, 1'b0, 0, 1'b0);
        chk("sbe_row",    out_row_err, 5'b00100);
        chk("sbe_col",    out_col_err, 4'b0001);
        chk("sbe_count",  err_count, 1);
        chk("sbe_sticky", sticky_err, 1'b1);

        // Odd mode, clean.
        load_frame({1'b0,4'h1}, {1'b1,4'h3}, {1'b0,4'h7}, {1'b1,4'hF}, {1'b1,4'h5});
        run_frame(1'b1, 1'b0, 0, 1'b0);
        chk("odd_fe", out_frame_err, 1'b0);

        // Saturation and clear: start from a cleared counter.
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        m_count  = 0;
        m_sticky = 1'b0;
        chk("clr_count", err_count, 0);
        load_frame({1'b1,4'h1}, {1'b0,4'h3}, {1'b1,4'h6}, {1'b0,4'hF}, {1'b0,4'hA});
        for (int k = 0; k < 5; k++) begin
            run_frame(1'b0, 1'b0, 0, 1'b0);
            chk("sat_count",  err_count, sat_exp[k]);
            chk("sat_sticky", sticky_err, 1'b1);
        end
        run_frame(1'b0, 1'b1, 0, 1'b0);
        chk("clr_coinc_count",  err_count, 1);
        chk("clr_coinc_sticky", sticky_err, 1'b1);

        // Reset mid-frame, then a clean frame with idle cycles between words.
        odd_mode = 1'b0;
        send_word(4'h1, 1'b1);
        send_word(4'h3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_count  = 0;
        m_sticky = 1'b0;
        chk("mid_rst_count",  err_count, 0);
        chk("mid_rst_sticky", sticky_err, 1'b0);
        chk("mid_rst_ready",  in_ready, 1'b1);
        load_frame({1'b1,4'h1}, {1'b0,4'h3}, {1'b1,4'h7}, {1'b0,4'hF}, {1'b0,4'hA});
        run_frame(1'b0, 1'b0, 1, 1'b0);
        chk("bp_fe",    out_frame_err, 1'b0);
        chk("bp_count", err_count, 0);

        // Randomized frames: random contents, mode, gaps, clears and mid-frame mode flips.
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i <= FRAME_LEN; i++) begin
                fr_d[i] = DATA_W'($urandom_range(0, 15));
                fr_p[i] = 1'($urandom_range(0, 1));
            end
            run_frame(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                      2, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Streaming two-dimensional parity checker, the parametrised successor to the 4-bit combinational even-parity checker. It accepts a frame of FRAME_LEN data words, each carrying a row parity bit, followed by one column-parity check word. For every frame it reports per-word row errors, the column error vector and a frame error flag. It keeps a saturating error counter and a sticky error flag, and sits between a serial receiver and downstream link-status logic.

## Interface
- DATA_W, 4: data word width; ≥1
- FRAME_LEN, 4: data words per frame, excluding the check word; ≥1
- CNT_W, 8: width of the frame-error counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- odd_mode  in  1  0 = even parity, 1 = odd parity; sampled on the first accepted word of each frame and held for that frame
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  DATA_W  data word, or the check word at index FRAME_LEN
- in_par  in  1  row parity bit for in_data
- clr_stat  in  1  synchronous clear of err_count and sticky_err
- out_valid  out  1  one-cycle frame-report strobe
- out_row_err  out  FRAME_LEN+1  bit i = row error on word i; bit FRAME_LEN = check word
- out_col_err  out  DATA_W  per-column parity mismatch
- out_frame_err  out  1  |out_row_err OR |out_col_err
- err_count  out  CNT_W  count of errored frames, saturating
- sticky_err  out  1  set by any errored frame, held until clr_stat or rst

## Operation
- Transfer occurs when in_valid && in_ready is high on a rising edge. Words presented while rst is high are ignored.
- FSM states:
  - COLLECT (word index 0..FRAME_LEN-1) → CHECK after the last data word is transferred.
  - CHECK → REPORT when the check word is transferred.
  - REPORT → COLLECT with index 0, unconditionally, after one cycle.
- Row check, applied to every word including the check word: error when ^{in_data,in_par} != odd_mode_latched. The result is stored into bit [index] of the row-error register.
- Column accumulator:
  - Cleared at frame start.
  - Each data word: col_acc ^= in_data.
  - On the check word: col_err = col_acc ^ in_data ^ {DATA_W{odd_mode_latched}}.
- Output registers:
  - Report outputs load on entry to REPORT.
  - out_row_err, out_col_err and out_frame_err hold their values until the next report.
- Statistics, updated on the REPORT-entry edge when out_frame_err = 1:
  - err_count increments and saturates at 2^CNT_W-1.
  - sticky_err is set.
- clr_stat:
  - Clears err_count and sticky_err.
  - If it coincides with an errored-frame update, the result is err_count = 1 and sticky_err = 1. The current frame is counted after the clear.
- Reset mid-frame discards the partial frame. Index, accumulator and row-error register all return to 0.

## Timing
- Reset values:
  - FSM = COLLECT, index 0, so in_ready = 1 once rst falls.
  - out_valid, out_row_err, out_col_err, out_frame_err, err_count and sticky_err are all 0.
- in_ready is a decode of the FSM state, with no combinational path from in_valid: 1 in COLLECT and CHECK, 0 in REPORT.
- Check word transferred at edge t:
  - out_valid = 1 during cycle t..t+1 only.
  - err_count and sticky_err are already updated in that same cycle.
  - in_ready returns to 1 from edge t+1 onward.
- Minimum frame period is FRAME_LEN+2 cycles. in_valid gaps stall the frame indefinitely with no timeout.
- odd_mode changes mid-frame have no effect until the next frame start.

## Structure
- Package parity_pkg holds:
  - the FSM state enum (COLLECT, CHECK, REPORT);
  - the index-width function clog2(FRAME_LEN+1);
  - function row_parity_err(data, par, odd).
- One sub-module, parity_row_check: combinational XOR-reduce plus mode compare. It is parametrised by DATA_W and instantiated once on the input word.
- Top level holds the FSM, index counter, accumulator, output registers and statistics.

## Test plan
All scenarios use DATA_W=4, FRAME_LEN=4.
- Even frame, clean:
  - Stimulus: words (data,par) 1/1, 3/0, 7/1, F/0, then check A/0.
  - Response: out_valid pulse with out_row_err=00000, out_col_err=0000, frame_err=0, err_count=0.
- Single-bit error:
  - Stimulus: as above but word 2 = 6/1.
  - Response: out_row_err=00100, out_col_err=0001, frame_err=1, err_count=1, sticky_err=1.
- Odd mode, clean:
  - Stimulus: odd_mode=1; words 1/0, 3/1, 7/0, F/1, then check 5/1.
  - Response: all error fields 0, frame_err=0.
- Saturation and clear (CNT_W=2):
  - Stimulus: five errored frames, then clr_stat asserted coincident with a sixth errored report.
  - Response: err_count sequence 1, 2, 3, 3, 3, then 1; sticky_err=1 throughout.
- Reset mid-frame and backpressure:
  - Stimulus: two words accepted, rst pulsed, then the clean even frame from the first scenario with one idle in_valid=0 cycle between each word.
  - Response: one report only, no errors, err_count=0; in_ready=0 only in the REPORT cycle.
